// File: rtl/diag_io_pkg.sv
// Shared constants for the diagnostic input conditioner: status field offsets,
// the CSR command bit and the maximum channel count.
package diag_io_pkg;

    localparam int STAT_LEVEL_LSB    = 0;
    localparam int STAT_RISE_LSB     = 8;
    localparam int STAT_FALL_LSB     = 16;
    localparam int CMD_SET_LIMIT_BIT = 31;
    localparam int MAX_INPUT_WIDTH   = 4;

endpackage

// File: rtl/diag_debounce_channel.sv
// One conditioned input: two-flop synchronizer, optional debounce counter,
// stable level and sticky rise/fall bits. Counter exists only with DIAG_INPUT_DEBOUNCE_EN.
module diag_debounce_channel #(
    parameter int   DEBOUNCE_WIDTH = 16,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      raw,
`ifdef DIAG_INPUT_DEBOUNCE_EN
    input  logic [DEBOUNCE_WIDTH-1:0] eff_limit,
`endif
    input  logic                      clr_rise,
    input  logic                      clr_fall,
    output logic                      level,
    output logic                      rise,
    output logic                      fall
);

    logic s1_r, s2_r, q_r, rise_r, fall_r;
    logic q_next_s, rise_next_s, fall_next_s;

`ifdef DIAG_INPUT_DEBOUNCE_EN
    logic [DEBOUNCE_WIDTH-1:0] cnt_r, cnt_next_s;

    // Debounce decision; >= lets a shortened limit fire on the next mismatching edge
    always_comb begin
        q_next_s   = q_r;
        cnt_next_s = '0;
        if (s2_r == q_r) begin
            cnt_next_s = '0;
        end else if (cnt_r >= (eff_limit - DEBOUNCE_WIDTH'(1))) begin
            q_next_s   = s2_r;
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + DEBOUNCE_WIDTH'(1);
        end
    end

    // Debounce counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end
`else
    logic [DEBOUNCE_WIDTH-1:0] unused_cnt_s;
    assign unused_cnt_s = '0;

    // Without debounce the stable level simply follows the synchronizer
    always_comb begin
        q_next_s = s2_r;
    end
`endif

    // Sticky edge bits: a set on the same edge as a clear wins
    always_comb begin
        rise_next_s = (rise_r & ~clr_rise) | (~q_r &  q_next_s);
        fall_next_s = (fall_r & ~clr_fall) | ( q_r & ~q_next_s);
    end

    // Synchronizer, stable level and sticky registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r   <= RESET_LEVEL;
            s2_r   <= RESET_LEVEL;
            q_r    <= RESET_LEVEL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            s1_r   <= raw;
            s2_r   <= s1_r;
            q_r    <= q_next_s;
            rise_r <= rise_next_s;
            fall_r <= fall_next_s;
        end
    end

    assign level = q_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/diag_input_conditioner.sv
// Conditions the diagnostic pins and aux switch, holds the debounce limit and
// assembles the W1C status word. Debounce is enabled by DIAG_INPUT_DEBOUNCE_EN.
module diag_input_conditioner
    import diag_io_pkg::*;
#(
    parameter int INPUT_WIDTH      = 4,
    parameter int DEBOUNCE_WIDTH   = 16,
    parameter int DEBOUNCE_DEFAULT = 1000
) (
    input  logic                   sysClk,
    input  logic                   sysReset_n,
    input  logic                   csrStrobe,
    input  logic [31:0]            GPIO_OUT,
    output logic [31:0]            status,
    input  logic [INPUT_WIDTH-1:0] rawIn,
    input  logic                   rawAuxSwitch_n,
    output logic [INPUT_WIDTH-1:0] diagnosticIn,
    output logic                   auxSwitch_n
);

    localparam int N = INPUT_WIDTH + 1;

    logic [N-1:0] raw_s, level_s, rise_s, fall_s, clr_rise_s, clr_fall_s;
    logic         clear_cmd_s;
    logic         unused_gpio_s;

    assign raw_s         = {rawAuxSwitch_n, rawIn};
    assign clear_cmd_s   = csrStrobe & ~GPIO_OUT[CMD_SET_LIMIT_BIT];
    assign unused_gpio_s = ^GPIO_OUT;

`ifdef DIAG_INPUT_DEBOUNCE_EN
    logic [DEBOUNCE_WIDTH-1:0] limit_r, eff_limit_s;

    // Debounce limit register, loaded by a set-limit CSR write
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            limit_r <= DEBOUNCE_WIDTH'(DEBOUNCE_DEFAULT);
        end else if (csrStrobe && GPIO_OUT[CMD_SET_LIMIT_BIT]) begin
            limit_r <= GPIO_OUT[DEBOUNCE_WIDTH-1:0];
        end else begin
            limit_r <= limit_r;
        end
    end

    assign eff_limit_s = (limit_r == '0) ? DEBOUNCE_WIDTH'(1) : limit_r;
`else
    logic [DEBOUNCE_WIDTH-1:0] unused_limit_s;
    assign unused_limit_s = DEBOUNCE_WIDTH'(DEBOUNCE_DEFAULT);
`endif

    for (genvar i = 0; i < N; i++) begin : g_ch
        assign clr_rise_s[i] = clear_cmd_s & GPIO_OUT[STAT_RISE_LSB + i];
        assign clr_fall_s[i] = clear_cmd_s & GPIO_OUT[STAT_FALL_LSB + i];

        diag_debounce_channel #(
            .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH),
            .RESET_LEVEL    ((i == INPUT_WIDTH) ? 1'b1 : 1'b0)
        ) u_ch (
            .clk       (sysClk),
            .rst_n     (sysReset_n),
            .raw       (raw_s[i]),
`ifdef DIAG_INPUT_DEBOUNCE_EN
            .eff_limit (eff_limit_s),
`endif
            .clr_rise  (clr_rise_s[i]),
            .clr_fall  (clr_fall_s[i]),
            .level     (level_s[i]),
            .rise      (rise_s[i]),
            .fall      (fall_s[i])
        );
    end

    // Status word assembled straight from channel registers
    always_comb begin
        status = 32'h0000_0000;
        status[STAT_LEVEL_LSB +: N] = level_s;
        status[STAT_RISE_LSB  +: N] = rise_s;
        status[STAT_FALL_LSB  +: N] = fall_s;
    end

    assign diagnosticIn = level_s[INPUT_WIDTH-1:0];
    assign auxSwitch_n  = level_s[INPUT_WIDTH];

endmodule

// File: tb/tb_diag_input_conditioner.sv
// Randomized bench for diag_input_conditioner with a run-length reference model
// and directed literal checks; honours DIAG_INPUT_DEBOUNCE_EN like the design.
module tb_diag_input_conditioner;

    localparam int IW = 4;
    localparam int DW = 16;
    localparam int DEF_LIMIT = 1000;
    localparam int N = IW + 1;
`ifdef DIAG_INPUT_DEBOUNCE_EN
    localparam int E = 4;
`else
    localparam int E = 1;
`endif

    logic          sysClk = 1'b0;
    logic          sysReset_n = 1'b1;
    logic          csrStrobe = 1'b0;
    logic [31:0]   GPIO_OUT = 32'h0;
    logic [31:0]   status;
    logic [IW-1:0] rawIn = '0;
    logic          rawAuxSwitch_n = 1'b1;
    logic [IW-1:0] diagnosticIn;
    logic          auxSwitch_n;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 sysClk = ~sysClk;

    diag_input_conditioner #(
        .INPUT_WIDTH      (IW),
        .DEBOUNCE_WIDTH   (DW),
        .DEBOUNCE_DEFAULT (DEF_LIMIT)
    ) dut (
        .sysClk         (sysClk),
        .sysReset_n     (sysReset_n),
        .csrStrobe      (csrStrobe),
        .GPIO_OUT       (GPIO_OUT),
        .status         (status),
        .rawIn          (rawIn),
        .rawAuxSwitch_n (rawAuxSwitch_n),
        .diagnosticIn   (diagnosticIn),
        .auxSwitch_n    (auxSwitch_n)
    );

    // Reference model: a channel's level flips once its synchronized value
    // (the raw pin two edges ago) has disagreed for effLimit consecutive edges.
    int m_limit;
    int m_eff;
    int m_run [N];
    bit m_lvl [N];
    bit m_rise[N];
    bit m_fall[N];
    bit d1    [N];
    bit d2    [N];

    always @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            m_limit = DEF_LIMIT;
            for (int c = 0; c < N; c++) begin
                m_lvl[c]  = (c == IW);
                d1[c]     = (c == IW);
                d2[c]     = (c == IW);
                m_run[c]  = 0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
            end
        end else begin
`ifdef DIAG_INPUT_DEBOUNCE_EN
            m_eff = (m_limit < 1) ? 1 : m_limit;
`else
            m_eff = 1;
`endif
            for (int c = 0; c < N; c++) begin
                if (csrStrobe && !GPIO_OUT[31]) begin
                    if (GPIO_OUT[8 + c])  m_rise[c] = 1'b0;
                    if (GPIO_OUT[16 + c]) m_fall[c] = 1'b0;
                end
                if (d2[c] != m_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] >= m_eff) begin
                        m_lvl[c] = d2[c];
                        m_run[c] = 0;
                        if (m_lvl[c]) m_rise[c] = 1'b1;
                        else          m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                d2[c] = d1[c];
                d1[c] = (c < IW) ? rawIn[c] : rawAuxSwitch_n;
            end
`ifdef DIAG_INPUT_DEBOUNCE_EN
            if (csrStrobe && GPIO_OUT[31]) m_limit = int'(GPIO_OUT[DW-1:0]);
`endif
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'h0;
        for (int c = 0; c < N; c++) begin
            s[c]      = m_lvl[c];
            s[8 + c]  = m_rise[c];
            s[16 + c] = m_fall[c];
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge sysClk) begin
        if (cmp_en) begin
            check("model_status", status, model_status());
            check("model_diag", 32'(diagnosticIn), 32'(model_status() & 32'hF));
            check("model_aux", 32'(auxSwitch_n), 32'(m_lvl[IW]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic csr_write(input logic [31:0] d);
        csrStrobe = 1'b1;
        GPIO_OUT  = d;
        @(negedge sysClk);
        csrStrobe = 1'b0;
        GPIO_OUT  = 32'h0;
    endtask

    initial begin
        #1 sysReset_n = 1'b0;
        tick(2);
        cmp_en = 1'b1;
        check("reset_status", status, 32'h0000_0010);
        check("reset_diag", 32'(diagnosticIn), 32'h0);
        check("reset_aux", 32'(auxSwitch_n), 32'h1);
        sysReset_n = 1'b1;
        tick(2);

        // Rising edge on channel 0, then a 3-cycle glitch
        csr_write(32'h8000_0004);
        rawIn[0] = 1'b1;
        tick(1 + E);
        check("ch0_before", 32'(diagnosticIn[0]), 32'h0);
        tick(1);
        check("ch0_rise", status, 32'h0000_0111);
        rawIn[0] = 1'b0;
        tick(3);
        rawIn[0] = 1'b1;
        tick(8);
        check("glitch_level", 32'(diagnosticIn[0]), 32'h1);
`ifdef DIAG_INPUT_DEBOUNCE_EN
        check("glitch_fall", 32'(status[16]), 32'h0);
`else
        check("glitch_fall", 32'(status[16]), 32'h1);
`endif
        csr_write(32'h0001_0100);
        check("w1c_ch0", status, 32'h0000_0011);

        // Aux switch press and clear of its fall bit
        rawAuxSwitch_n = 1'b0;
        tick(10);
        check("aux_low", 32'(auxSwitch_n), 32'h0);
        check("aux_fall", 32'(status[20]), 32'h1);
        csr_write(32'h0010_0000);
        check("aux_fall_clr", 32'(status[20]), 32'h0);
        rawAuxSwitch_n = 1'b1;
        tick(10);
        csr_write(32'h0000_1000);

        // Clear of rise[1] on the very edge q[1] rises: set wins
        rawIn[1] = 1'b1;
        tick(E + 1);
        csr_write(32'h0000_0200);
        check("set_wins", 32'(status[9]), 32'h1);
        csr_write(32'h0000_0200);
        check("rise1_clr", 32'(status[9]), 32'h0);

        // Limit 0 behaves as limit 1
        csr_write(32'h8000_0000);
        rawIn[2] = 1'b1;
        tick(2);
        check("lim0_k1", 32'(diagnosticIn[2]), 32'h0);
        tick(1);
        check("lim0_k2", 32'(diagnosticIn[2]), 32'h1);
        csr_write(32'h0000_0400);

        // Reset in the middle of a count
        csr_write(32'h8000_0004);
        rawIn[3] = 1'b1;
        tick(5);
        #2 sysReset_n = 1'b0;
        tick(1);
        check("rst_mid_status", status, 32'h0000_0010);
        sysReset_n = 1'b1;
        csr_write(32'h8000_0004);
        tick(E);
        check("rst_recount", status, 32'h0000_0010);
        tick(1);
        check("rst_settle", status, 32'h0000_0F1F);

        // Randomized phase against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < IW; c++) begin
                if ($urandom_range(0, 5) == 0) rawIn[c] = ~rawIn[c];
            end
            if ($urandom_range(0, 7) == 0) rawAuxSwitch_n = ~rawAuxSwitch_n;
            if ($urandom_range(0, 19) == 0) begin
                csrStrobe = 1'b1;
                if ($urandom_range(0, 2) == 0) GPIO_OUT = 32'h8000_0000 | 32'($urandom_range(0, 6));
                else                           GPIO_OUT = $urandom & 32'h001F_1F00;
            end else begin
                csrStrobe = 1'b0;
                GPIO_OUT  = 32'h0;
            end
            if (cyc == 1500) begin
                #2 sysReset_n = 1'b0;
                @(negedge sysClk);
                sysReset_n = 1'b1;
            end else begin
                @(negedge sysClk);
            end
        end
        csrStrobe = 1'b0;
        tick(2);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
